// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 16;
  localparam int IDX_W     = $clog2(DEF_N_REQ);
  localparam int LVL_W     = $clog2(DEF_DEPTH + 1);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority finder starting at a pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Walk from the farthest slot back toward ptr so the nearest valid one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-locked arbiter for a shared FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(N_REQ)-1:0]      fifo_wr_src,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  input  logic                          fifo_full,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          ovf_err
);

  localparam int IW    = $clog2(N_REQ);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int CW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [IW-1:0] IDX_ONE  = 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);
  localparam logic [LW-1:0] LVL_ONE  = 1;
  localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [IW-1:0]         wr_src_q, wr_src_d;
  logic                  ovf_q, ovf_d;

  logic                  scan_found;
  logic [IW-1:0]         scan_idx;
  logic                  owner_hold;
  logic                  has_winner;
  logic [IW-1:0]         winner;
  logic                  credit_ok;
  logic                  accept;
  logic                  rd_ok;
  logic [CW-1:0]         cnt_eff;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (scan_found),
    .idx_o   (scan_idx)
  );

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IDX_LAST) ? '0 : x + IDX_ONE;
  endfunction

  // Winner selection: a live lock keeps the owner, otherwise the rotating scan decides.
  always_comb begin
    owner_hold = (state_q == LOCKED) && req_valid[owner_q];
    has_winner = owner_hold || scan_found;
    winner     = owner_hold ? owner_q : scan_idx;
    credit_ok  = (level_q < LVL_MAX);
    accept     = has_winner && credit_ok;
    rd_ok      = fifo_rd_en && !fifo_empty && (level_q != '0);
    req_ready  = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Burst FSM next state; a burst counts only while the same owner keeps winning.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    cnt_eff     = ((state_q == LOCKED) && (winner == owner_q)) ? burst_cnt_q : '0;
    if (accept) begin
      if (cnt_eff == CNT_LAST) begin
        state_d     = UNLOCKED;
        burst_cnt_d = '0;
        rr_ptr_d    = wrap_inc(winner);
      end else begin
        state_d     = LOCKED;
        owner_d     = winner;
        burst_cnt_d = cnt_eff + CNT_ONE;
      end
    end else if (credit_ok && (state_q == LOCKED) && !req_valid[owner_q]) begin
      state_d     = UNLOCKED;
      burst_cnt_d = '0;
      rr_ptr_d    = wrap_inc(owner_q);
    end
  end

  // Output register, credit counter and sticky overflow flag next state.
  always_comb begin
    wr_en_d   = accept;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (accept) begin
      wr_data_d = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      wr_src_d  = winner;
    end
    level_d = level_q;
    if (accept && !rd_ok) begin
      level_d = level_q + LVL_ONE;
    end else if (!accept && rd_ok) begin
      level_d = level_q - LVL_ONE;
    end
    ovf_d = ovf_q || (wr_en_q && fifo_full);
  end

  // All state registers; reset drops any write still sitting in the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      level_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_src_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      level_q     <= level_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_src_q    <= wr_src_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_src  = wr_src_q;
  assign level        = level_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - table-driven self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int BURST_LEN  = 4;

  logic                        clk;
  logic                        reset;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_wr_data;
  logic [1:0]                  fifo_wr_src;
  logic                        fifo_rd_en;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [4:0]                  level;
  logic                        ovf_err;

  fifo_wr_arbiter #(
    .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_src(fifo_wr_src),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .level(level), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [3:0] valid;
    logic       rd;
    logic [3:0] exp_ready;
    logic       exp_wr;
    logic [1:0] exp_src;
    logic [4:0] exp_lvl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rb, input logic [3:0] v, input logic rd,
                     input logic [3:0] er, input logic ew, input logic [1:0] es,
                     input logic [4:0] el);
    vec_t e;
    e.rst_before = rb; e.valid = v; e.rd = rd;
    e.exp_ready = er; e.exp_wr = ew; e.exp_src = es; e.exp_lvl = el;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0; fifo_rd_en = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'hA0 + 8'(i);

    // Continuous requests from all four, drained every cycle: bursts of four per owner.
    for (int k = 0; k < 17; k++)
      add(k == 0, 4'b1111, 1'b1, 4'(1 << ((k / 4) % 4)), 1'b1, 2'((k / 4) % 4), 5'd1);

    // Requester 1 then drops; 2 and 3 compete, 2 gets a full burst first.
    add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 5'd1);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 5'd2);
    add(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd3);
    add(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd4);
    add(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd5);
    add(1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 5'd6);
    add(1'b0, 4'b1100, 1'b0, 4'b1000, 1'b1, 2'd3, 5'd7);

    // Fill to DEPTH with no reads, then one read frees exactly one credit.
    for (int k = 0; k < 16; k++)
      add(k == 0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 5'(k + 1));
    add(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd16);
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd15);
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd16);
    add(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd16);

    // Two locked accepts so the mid-operation reset below hits a pending write.
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd1);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 5'd2);

    #1;
    chk("reset_wr_en", fifo_wr_en, 0);
    chk("reset_level", level, 0);
    chk("reset_src", fifo_wr_src, 0);
    chk("reset_data", fifo_wr_data, 0);
    chk("reset_ovf", ovf_err, 0);

    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset();
      @(negedge clk);
      req_valid  = tbl[n].valid;
      fifo_rd_en = tbl[n].rd;
      #1;
      chk($sformatf("ready[%0d]", n), req_ready, tbl[n].exp_ready);
      @(posedge clk);
      #1;
      chk($sformatf("wr_en[%0d]", n), fifo_wr_en, tbl[n].exp_wr);
      chk($sformatf("src[%0d]", n), fifo_wr_src, tbl[n].exp_src);
      chk($sformatf("level[%0d]", n), level, tbl[n].exp_lvl);
      if (tbl[n].exp_wr)
        chk($sformatf("data[%0d]", n), fifo_wr_data, 32'(8'hA0 + 8'(tbl[n].exp_src)));
      chk($sformatf("ovf[%0d]", n), ovf_err, 0);
    end

    // Asynchronous reset while locked with a write registered.
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_wr_en", fifo_wr_en, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_src", fifo_wr_src, 0);
    chk("async_rst_data", fifo_wr_data, 0);
    req_valid = 4'b1010;
    #1;
    chk("async_rst_ready", req_ready, 4'b0010);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    chk("post_rst_wr_en", fifo_wr_en, 1);
    chk("post_rst_src", fifo_wr_src, 1);
    chk("post_rst_data", fifo_wr_data, 8'hA1);

    // Overflow: fifo_full seen while a write is registered sets a sticky flag.
    do_reset();
    req_valid = 4'b0001;
    @(posedge clk);
    #1;
    chk("ovf_pre_wr", fifo_wr_en, 1);
    req_valid = 4'b0000;
    fifo_full = 1'b1;
    chk("ovf_pre_flag", ovf_err, 0);
    @(posedge clk);
    #1;
    chk("ovf_set", ovf_err, 1);
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", ovf_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
